req_ack_arbiter: RTL
====================

Name: req_ack_arbiter

Overview:
- Shares one req/ack-handshaked resource among N requesters.
- Arbitrates pending requests round-robin and forwards the winner's request to the resource as a level req.
- Waits an unbounded or bounded number of cycles for the resource ack, then returns a one-cycle ack to the winner.
- Sits between client agents and a single slave whose ack latency is variable (1..any cycles).

Parameters:
- N, 4, number of requesters (2..16).
- TIMEOUT_CYC, 0, max WAIT cycles before abort; 0 = wait forever.
- CW, 16, timeout counter width; TIMEOUT_CYC must be < 2**CW.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_i  in  N  per-requester request level, held until own ack_o/err_o.
- ack_o  out  N  one-cycle completion pulse to the granted requester.
- err_o  out  N  one-cycle timeout-abort pulse to the granted requester.
- res_req_o  out  1  request to shared resource, high for the whole WAIT.
- res_ack_i  in  1  resource ack, sampled only in WAIT.
- grant_o  out  N  one-hot current owner; 0 when IDLE.
- grant_id_o  out  $clog2(N)  index of current/last owner.
- busy_o  out  1  high in WAIT or RECOVER.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, all outputs 0, rr pointer=0 (requester 0 has top priority), timeout counter=0. Reset mid-transaction aborts silently: no ack_o/err_o; res_req_o low next cycle.
- All outputs are registered.
- States:
  - IDLE: if any req_i bit is high, select the first set bit searching from ptr, ptr+1, ..., wrapping mod N. Load grant_o/grant_id_o, set res_req_o=1, clear counter, go to WAIT. Latency is 1 cycle from req_i sampled high to res_req_o high.
  - WAIT: res_req_o=1, grant held. Each cycle:
    - If res_ack_i=1: ack_o[g]=1 next cycle, res_req_o=0, ptr=(g+1) mod N, go to RECOVER.
    - Else if TIMEOUT_CYC!=0 and counter==TIMEOUT_CYC-1: err_o[g]=1 next cycle, res_req_o=0, ptr=(g+1) mod N, go to RECOVER.
    - Else counter++ (saturating at 2**CW-1 when TIMEOUT_CYC=0).
  - RECOVER: lasts exactly 1 cycle. ack_o/err_o pulse visible here, grant_o=0, req_i ignored, then IDLE. Requester must drop req_i in this cycle. A req_i still high in IDLE is a new request.
- Earliest ack: res_ack_i high at the first posedge after res_req_o rises, giving ack_o 2 cycles after the req_i sample. Minimum back-to-back period per transaction is 3 cycles.
- res_ack_i=1 on the same edge as the timeout terminal count: ack wins, no err_o.
- res_ack_i in IDLE/RECOVER is ignored; no state change.
- Granted req_i deasserted during WAIT: ignored, transaction runs to completion and ack_o still pulses.
- ack_o and err_o are never both set; at most one bit of either is set, and it equals grant_id_o.
- Changing non-granted req_i bits during WAIT has no effect until the next IDLE.

Test Plan:
- N=4, TIMEOUT_CYC=0. rst 2 cycles, then req_i=0001 at negedge. Expect: res_req_o=1 and grant_o=0001 next posedge. Drive res_ack_i=1 for 1 cycle after 3 WAIT cycles. Expect ack_o=0001 for exactly 1 cycle, busy_o low 2 cycles after ack.
- req_i=1111 held, resource acks after 1 cycle each time. Expect grant order 0,1,2,3,0 with a 3-cycle period each, and exactly one ack_o bit per transaction.
- TIMEOUT_CYC=8, req_i=0100, res_ack_i never high. Expect res_req_o high exactly 8 cycles, err_o=0100 one cycle, no ack_o, ptr advances so the next grant with req_i=1111 is requester 3.
- TIMEOUT_CYC=8, res_ack_i=1 on the 8th WAIT cycle. Expect ack_o pulse and err_o stays 0.
- Assert rst during WAIT with req_i=0010. Expect all outputs 0 at the next cycle, no ack_o/err_o. After rst is released with req_i still 0010, grant is re-issued to requester 1.
- res_ack_i=1 pulsed in IDLE with req_i=0. Expect no state change, busy_o=0, ack_o=0. Use SVA throughout: $rose(res_req_o) |-> ##[1:$] res_ack_i or err_o; onehot0(grant_o).

Source files
------------

// File: rtl/req_ack_arbiter.sv
// Purpose : round-robin arbiter sharing one req/ack resource among N requesters.
// Latency : req_i -> res_req_o 1 cycle; res_ack_i -> ack_o 1 cycle; 3-cycle minimum period.
// Backpressure: requesters hold req_i until their ack_o/err_o; the resource stalls via res_ack_i.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   req_i[N]     per-requester request level
//   ack_o[N]     one-cycle completion pulse to the owner
//   err_o[N]     one-cycle timeout-abort pulse to the owner
//   res_req_o    level request to the shared resource (high throughout WAIT)
//   res_ack_i    resource acknowledge, only looked at in WAIT
//   grant_o[N]   one-hot current owner, 0 outside WAIT
//   grant_id_o   index of the current/last owner
//   busy_o       high in WAIT or RECOVER
module req_ack_arbiter #(
  parameter int N           = 4,
  parameter int TIMEOUT_CYC = 0,
  parameter int CW          = 16,
  localparam int IW         = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  ack_o,
  output logic [N-1:0]  err_o,
  output logic          res_req_o,
  input  logic          res_ack_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_id_o,
  output logic          busy_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_RECOVER = 2'd2;

  // TIMEOUT_CYC == 0 disables the abort path entirely.
  localparam bit            TO_EN    = (TIMEOUT_CYC != 0);
  localparam logic [CW-1:0] TERM_CNT = CW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
  localparam logic [N-1:0]  ONE      = {{(N-1){1'b0}}, 1'b1};

  logic [1:0]    state;
  logic [IW-1:0] ptr;
  logic [CW-1:0] cnt;

  logic          pick_vld;
  logic [IW-1:0] pick_id;
  logic [IW-1:0] idx;
  logic [IW-1:0] nxt_ptr;

  // Search ptr, ptr+1, ... wrapping mod N. Walking k downwards lets the
  // smallest offset (highest priority) overwrite any later hit.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    idx      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req_i[idx]) begin
        pick_vld = 1'b1;
        pick_id  = idx;
      end
    end
  end

  assign nxt_ptr = IW'((int'(grant_id_o) + 1) % N);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      cnt        <= '0;
      ack_o      <= '0;
      err_o      <= '0;
      res_req_o  <= 1'b0;
      grant_o    <= '0;
      grant_id_o <= '0;
      busy_o     <= 1'b0;
    end else begin
      // Completion pulses last exactly one cycle.
      ack_o <= '0;
      err_o <= '0;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            grant_o    <= ONE << pick_id;
            grant_id_o <= pick_id;
            res_req_o  <= 1'b1;
            busy_o     <= 1'b1;
            cnt        <= '0;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          // An ack on the terminal-count edge takes precedence over the abort.
          if (res_ack_i) begin
            ack_o     <= grant_o;
            grant_o   <= '0;
            res_req_o <= 1'b0;
            ptr       <= nxt_ptr;
            state     <= S_RECOVER;
          end else if (TO_EN && (cnt == TERM_CNT)) begin
            err_o     <= grant_o;
            grant_o   <= '0;
            res_req_o <= 1'b0;
            ptr       <= nxt_ptr;
            state     <= S_RECOVER;
          end else if (cnt != {CW{1'b1}}) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RECOVER: begin
          // One dead cycle so the owner can drop req_i before re-arbitration.
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          grant_o   <= '0;
          res_req_o <= 1'b0;
          busy_o    <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
